// File: rtl/sar_search_ctrl_if.sv
// Comparator-loop bundle for the successive-approximation search controller.
// The controller (master) drives the trial operand and status; the requester/comparator side is the slave.
interface sar_search_ctrl_if #(
  parameter int WIDTH = 4
);
  // start is a level request accepted on any rising edge where the controller is idle
  // (state_dbg == 0). There is no ready: a start seen while busy is simply ignored.
  // done is a one-cycle pulse and result/error are valid from that pulse onward.
  logic             start;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             error;
  logic             state_dbg;

  modport master (
    input  start, cmp_gt, cmp_eq, cmp_lt,
    output trial, busy, done, result, error, state_dbg
  );

  modport slave (
    output start, cmp_gt, cmp_eq, cmp_lt,
    input  trial, busy, done, result, error, state_dbg
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search over an external combinational comparator:
// recovers the comparator's A operand MSB first, exiting early on equality.
module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  sar_search_ctrl_if.master bus
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
  localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;

  logic             flags_ok;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] next_trial;

  // Flags are judged against the registered trial, so this is all combinational on stable inputs.
  always_comb begin
    flags_ok = ({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} == 3'b100) ||
               ({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} == 3'b010) ||
               ({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} == 3'b001);
    v = trial_q;
    if (bus.cmp_lt) begin
      v[idx] = 1'b0;
    end
    next_trial = v | (ONE << (idx - IW'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= TOP_IDX;
      trial_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            trial_q <= MSB;
            idx     <= TOP_IDX;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            state   <= PROBE;
          end
        end
        PROBE: begin
          if (!flags_ok) begin
            result_q <= trial_q;
            error_q  <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else if (bus.cmp_eq) begin
            result_q <= trial_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else if (idx == '0) begin
            result_q <= v;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            // Keep or clear the probed bit, then tentatively set the next lower one.
            trial_q <= next_trial;
            idx     <= idx - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trial     = trial_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.error     = error_q;
  assign bus.state_dbg = (state == PROBE);
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: WIDTH=2 and WIDTH=4 instances against a behavioural comparator,
// with directed, error, reset-abort, back-to-back and exhaustive searches.
module tb_sar_search_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic sel4;
  logic bad;
  int   a_val;
  int   checks = 0;
  int   passes = 0;

  sar_search_ctrl_if #(.WIDTH(2)) if2 ();
  sar_search_ctrl_if #(.WIDTH(4)) if4 ();

  sar_search_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  sar_search_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  always #5 clk = ~clk;

  logic [1:0] a2;
  logic [3:0] a4;
  assign a2 = a_val[1:0];
  assign a4 = a_val[3:0];

  // Behavioural comparators; 'bad' forces gt and lt together.
  assign if2.start  = start & ~sel4;
  assign if2.cmp_gt = bad ? 1'b1 : (a2 > if2.trial);
  assign if2.cmp_eq = bad ? 1'b0 : (a2 == if2.trial);
  assign if2.cmp_lt = bad ? 1'b1 : (a2 < if2.trial);
  assign if4.start  = start & sel4;
  assign if4.cmp_gt = bad ? 1'b1 : (a4 > if4.trial);
  assign if4.cmp_eq = bad ? 1'b0 : (a4 == if4.trial);
  assign if4.cmp_lt = bad ? 1'b1 : (a4 < if4.trial);

  logic [3:0] obs_trial, obs_result;
  logic       obs_busy, obs_done, obs_error;
  assign obs_trial  = sel4 ? if4.trial  : {2'b00, if2.trial};
  assign obs_result = sel4 ? if4.result : {2'b00, if2.result};
  assign obs_busy   = sel4 ? if4.busy   : if2.busy;
  assign obs_done   = sel4 ? if4.done   : if2.done;
  assign obs_error  = sel4 ? if4.error  : if2.error;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One full search. The model derives the trial sequence directly from A:
  // probe j tests A's top j bits followed by a 1 and zeros, stopping on a hit or the last bit.
  task automatic search(input bit w4, input int a, input bit spam, input bit badf);
    int w;
    int k;
    int t;
    int exp_res;
    int dn;
    int done_cyc;
    int probes;
    int both;
    logic [3:0] exp_q[$];
    w = w4 ? 4 : 2;
    exp_q = {};
    k = 0;
    for (int j = 0; j < w; j++) begin
      t = ((a >> (w - j)) << (w - j)) | (1 << (w - 1 - j));
      exp_q.push_back(t[3:0]);
      k = j + 1;
      if (t == a || badf) break;
    end
    exp_res = badf ? (1 << (w - 1)) : a;
    dn = 0; done_cyc = 0; probes = 0; both = 0;

    @(negedge clk);
    sel4 = w4; a_val = a; bad = badf; start = 1'b1;
    for (int c = 1; c <= w + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (obs_done) begin
        dn++;
        done_cyc = c;
        if (obs_busy) both++;
      end
      if (obs_busy) begin
        probes++;
        if (exp_q.size() > 0) chk("trial", obs_trial, exp_q.pop_front());
        if (spam) start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    bad = 1'b0;
    chk("done_count", dn, 1);
    chk("done_latency", done_cyc, k + 1);
    chk("probe_count", probes, k);
    chk("result", obs_result, exp_res);
    chk("error", obs_error, badf);
    chk("busy_with_done", both, 0);
  endtask

  initial begin
    int waited;
    rst = 1'b1; start = 1'b0; sel4 = 1'b1; bad = 1'b0; a_val = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_trial4", if4.trial, 0);
    chk("rst_busy4", if4.busy, 0);
    chk("rst_done4", if4.done, 0);
    chk("rst_result4", if4.result, 0);
    chk("rst_error4", if4.error, 0);
    chk("rst_state4", if4.state_dbg, 0);
    chk("rst_trial2", if2.trial, 0);
    chk("rst_busy2", if2.busy, 0);
    rst = 1'b0;

    // Directed cases
    search(1'b0, 2, 1'b0, 1'b0);
    search(1'b0, 3, 1'b0, 1'b0);
    search(1'b0, 0, 1'b0, 1'b0);
    search(1'b1, 11, 1'b0, 1'b0);
    search(1'b1, 0, 1'b0, 1'b0);
    search(1'b1, 5, 1'b0, 1'b1);
    search(1'b1, 5, 1'b0, 1'b0);
    search(1'b1, 7, 1'b1, 1'b0);

    // Reset during the second probe aborts the search
    @(negedge clk);
    sel4 = 1'b1; a_val = 13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", obs_busy, 1);
    chk("abort_trial_before", obs_trial, 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_trial", obs_trial, 0);
    chk("abort_busy", obs_busy, 0);
    chk("abort_done", obs_done, 0);
    chk("abort_result", obs_result, 0);
    chk("abort_error", obs_error, 0);
    waited = 0;
    repeat (5) begin
      @(negedge clk);
      if (obs_done) waited++;
    end
    chk("abort_no_done", waited, 0);
    search(1'b1, 13, 1'b0, 1'b0);

    // Back-to-back: start sampled while done is high
    @(negedge clk);
    sel4 = 1'b1; a_val = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy1", obs_busy, 1);
    @(negedge clk);
    chk("b2b_done1", obs_done, 1);
    chk("b2b_result1", obs_result, 8);
    a_val = 6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy2", obs_busy, 1);
    chk("b2b_trial2", obs_trial, 8);
    chk("b2b_done_low", obs_done, 0);
    waited = 0;
    while (!obs_done && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("b2b_done2", obs_done, 1);
    chk("b2b_result2", obs_result, 6);
    chk("b2b_error2", obs_error, 0);

    // Exhaustive and random
    for (int a = 0; a < 4; a++) search(1'b0, a, 1'b0, 1'b0);
    for (int a = 0; a < 16; a++) search(1'b1, a, 1'($urandom_range(0, 1)), 1'b0);
    repeat (8) search(1'b1, int'($urandom_range(0, 15)), 1'b1, 1'b0);
    search(1'b0, 1, 1'b0, 1'b1);
    search(1'b0, 1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
